// File: rtl/updown_seq_decoder.sv
// updown_seq_decoder
// Receive-side observer for the 2-bit up/down counter family. Samples the
// counter bus on every clk edge, recovers the direction the counter was
// driven with, reports lock, holds, direction reversals and illegal jumps,
// and keeps a saturating count of illegal jumps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no valid previous sample; next edge only captures q_in
// ACQUIRE | counting consecutive same-direction single steps
// LOCKED  | consistent stepping seen; dir is valid, reversals flagged
module updown_seq_decoder #(
  parameter int WIDTH    = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [WIDTH-1:0] q_in,
  output logic             dir,
  output logic             locked,
  output logic             dir_chg,
  output logic             hold_p,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [WIDTH-1:0] STEP_ONE   = WIDTH'(1);
  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run_cnt;
  logic             r_cand;
  logic             r_dir;
  logic             r_locked;
  logic             r_dir_chg;
  logic             r_hold_p;
  logic             r_step_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_delta;
  logic             w_up;
  logic             w_dn;
  logic             w_hold;
  logic [3:0]       w_run_step;
  logic [1:0]       w_state_nxt;
  logic [3:0]       w_run_nxt;
  logic             w_cand_nxt;
  logic             w_dir_nxt;
  logic             w_locked_nxt;
  logic             w_dir_chg_nxt;
  logic             w_hold_nxt;
  logic             w_step_err_nxt;

  // Modular difference makes max->0 an up step and 0->max a down step.
  assign w_delta = q_in - r_prev;
  assign w_up    = (w_delta == STEP_ONE);
  assign w_dn    = (w_delta == {WIDTH{1'b1}});
  assign w_hold  = (w_delta == '0);

  // A step agreeing with the candidate (or the first step of a run) extends
  // the run; an opposite step starts a fresh run of length one.
  assign w_run_step = ((r_run_cnt == 4'd0) || (w_up == r_cand)) ?
                      (r_run_cnt + 4'd1) : 4'd1;

  // Next-state decode: classify the step and decide state, lock and pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run_cnt;
    w_cand_nxt     = r_cand;
    w_dir_nxt      = r_dir;
    w_locked_nxt   = r_locked;
    w_dir_chg_nxt  = 1'b0;
    w_hold_nxt     = 1'b0;
    w_step_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = ACQUIRE;
        w_run_nxt   = 4'd0;
      end
      ACQUIRE: begin
        if (w_up || w_dn) begin
          w_cand_nxt = w_up;
          w_run_nxt  = w_run_step;
          // Lock entry is not a reversal, so no dir_chg here.
          if (w_run_step == LOCK_TARGET) begin
            w_state_nxt  = LOCKED;
            w_dir_nxt    = w_up;
            w_locked_nxt = 1'b1;
          end
        end else if (w_hold) begin
          w_hold_nxt = 1'b1;
        end else begin
          w_step_err_nxt = 1'b1;
          w_run_nxt      = 4'd0;
        end
      end
      LOCKED: begin
        if (w_up || w_dn) begin
          if (w_up != r_dir) begin
            w_dir_nxt     = w_up;
            w_dir_chg_nxt = 1'b1;
          end
        end else if (w_hold) begin
          w_hold_nxt = 1'b1;
        end else begin
          w_step_err_nxt = 1'b1;
          w_locked_nxt   = 1'b0;
          w_run_nxt      = 4'd0;
          w_state_nxt    = ACQUIRE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_run_nxt    = 4'd0;
        w_locked_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer state, run tracking and previous-sample capture.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_state   <= IDLE;
      r_prev    <= '0;
      r_run_cnt <= 4'd0;
      r_cand    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= q_in;
      r_run_cnt <= w_run_nxt;
      r_cand    <= w_cand_nxt;
    end
  end

  // Registered direction, lock flag and single-cycle event pulses.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_dir      <= 1'b0;
      r_locked   <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_hold_p   <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_dir      <= w_dir_nxt;
      r_locked   <= w_locked_nxt;
      r_dir_chg  <= w_dir_chg_nxt;
      r_hold_p   <= w_hold_nxt;
      r_step_err <= w_step_err_nxt;
    end
  end

  // Illegal-jump counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_err_cnt <= '0;
    end else if (w_step_err_nxt && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign dir      = r_dir;
  assign locked   = r_locked;
  assign dir_chg  = r_dir_chg;
  assign hold_p   = r_hold_p;
  assign step_err = r_step_err;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_updown_seq_decoder.sv
// Testbench for updown_seq_decoder. Two instances share one stimulus:
// inst0 uses defaults (LOCK_CNT=2, ERR_W=8), inst1 uses LOCK_CNT=1, ERR_W=2.
module tb_updown_seq_decoder;

  logic       clk;
  logic       CLR;
  logic [1:0] q_in;

  logic       o0_dir, o0_locked, o0_dchg, o0_hold, o0_serr;
  logic [7:0] o0_err;
  logic       o1_dir, o1_locked, o1_dchg, o1_hold, o1_serr;
  logic [1:0] o1_err;

  int errors = 0;
  int checks = 0;

  updown_seq_decoder #(.WIDTH(2), .LOCK_CNT(2), .ERR_W(8)) u_dut0 (
    .clk(clk), .CLR(CLR), .q_in(q_in),
    .dir(o0_dir), .locked(o0_locked), .dir_chg(o0_dchg),
    .hold_p(o0_hold), .step_err(o0_serr), .err_cnt(o0_err)
  );

  updown_seq_decoder #(.WIDTH(2), .LOCK_CNT(1), .ERR_W(2)) u_dut1 (
    .clk(clk), .CLR(CLR), .q_in(q_in),
    .dir(o1_dir), .locked(o1_locked), .dir_chg(o1_dchg),
    .hold_p(o1_hold), .step_err(o1_serr), .err_cnt(o1_err)
  );

  logic [12:0] obs0, obs1;
  assign obs0 = {o0_dir, o0_locked, o0_dchg, o0_hold, o0_serr, o0_err};
  assign obs1 = {o1_dir, o1_locked, o1_dchg, o1_hold, o1_serr, 6'b0, o1_err};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model: mode 0 = no history, 1 = searching, 2 = locked.
  int lock_cnt[2] = '{2, 1};
  int err_max[2]  = '{255, 3};
  int m_mode[2];
  int m_run[2];
  bit m_cand[2];
  bit m_dir[2];
  bit m_locked[2];
  bit m_dchg[2];
  bit m_hold[2];
  bit m_serr[2];
  int m_err[2];
  int m_prev;

  function automatic logic [12:0] exp_vec(input int i);
    exp_vec = {m_dir[i], m_locked[i], m_dchg[i], m_hold[i], m_serr[i], 8'(m_err[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_run[i] = 0; m_cand[i] = 0; m_dir[i] = 0;
      m_locked[i] = 0; m_dchg[i] = 0; m_hold[i] = 0; m_serr[i] = 0;
      m_err[i] = 0;
    end
    m_prev = 0;
  endtask

  task automatic model_step(input int q);
    int d;
    bit s;
    d = (q - m_prev + 4) % 4;
    for (int i = 0; i < 2; i++) begin
      m_dchg[i] = 0; m_hold[i] = 0; m_serr[i] = 0;
      if (m_mode[i] == 0) begin
        m_mode[i] = 1;
        m_run[i]  = 0;
      end else if (d == 0) begin
        m_hold[i] = 1;
      end else if (d == 2) begin
        m_serr[i] = 1;
        if (m_err[i] < err_max[i]) m_err[i] = m_err[i] + 1;
        m_run[i] = 0;
        if (m_mode[i] == 2) begin
          m_mode[i]   = 1;
          m_locked[i] = 0;
        end
      end else begin
        s = (d == 1);
        if (m_mode[i] == 1) begin
          if (m_run[i] == 0 || s == m_cand[i]) m_run[i] = m_run[i] + 1;
          else m_run[i] = 1;
          m_cand[i] = s;
          if (m_run[i] == lock_cnt[i]) begin
            m_mode[i]   = 2;
            m_dir[i]    = s;
            m_locked[i] = 1;
          end
        end else if (s != m_dir[i]) begin
          m_dir[i]  = s;
          m_dchg[i] = 1;
        end
      end
    end
    m_prev = q;
  endtask

  // Drive q on the falling edge, let one rising edge classify it, sample #1 later.
  task automatic apply(input int q);
    @(negedge clk);
    q_in = 2'(q);
    @(posedge clk);
    model_step(q);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of the high phase; returns before the falling edge.
  task automatic mid_reset();
    #2;
    CLR = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    CLR  = 1'b0;
    q_in = 2'd0;
    model_reset();
    #1;
    if (obs0 !== 13'd0) begin errors++; $display("FAIL reset inst0 got=%h exp=0", obs0); end
    checks++;
    if (obs1 !== 13'd0) begin errors++; $display("FAIL reset inst1 got=%h exp=0", obs1); end
    checks++;
    #3;
    CLR = 1'b1;
  endtask

  task automatic test_lock_up();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) begin
      apply(seq[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL lock_up[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL lock_up[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if (k == 2) begin
        if ({o0_locked, o0_dir} !== 2'b11) begin errors++; $display("FAIL lock_up_3rd locked,dir got=%b exp=11", {o0_locked, o0_dir}); end
        checks++;
      end
    end
    if ({o0_serr, o0_err} !== 9'd0) begin errors++; $display("FAIL lock_up_noerr got=%h exp=0", {o0_serr, o0_err}); end
    checks++;
  endtask

  task automatic test_dir_change();
    int seq[4]  = '{1, 0, 3, 2};
    bit pulse[4] = '{0, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      apply(seq[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL dir_chg[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL dir_chg[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if (o0_dchg !== pulse[k]) begin errors++; $display("FAIL dir_chg_pulse[%0d] got=%b exp=%b", k, o0_dchg, pulse[k]); end
      checks++;
    end
    if ({o0_locked, o0_dir} !== 2'b10) begin errors++; $display("FAIL dir_chg_final locked,dir got=%b exp=10", {o0_locked, o0_dir}); end
    checks++;
  endtask

  task automatic test_jump_relock();
    int seq[5] = '{1, 0, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      apply(seq[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL jump[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL jump[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if (k == 2) begin
        if ({o0_serr, o0_locked, o0_err} !== {1'b1, 1'b0, 8'd1}) begin
          errors++; $display("FAIL jump_unlock serr,locked,err got=%h exp=%h", {o0_serr, o0_locked, o0_err}, {1'b1, 1'b0, 8'd1});
        end
        checks++;
      end
    end
    if ({o0_locked, o0_dir} !== 2'b11) begin errors++; $display("FAIL relock locked,dir got=%b exp=11", {o0_locked, o0_dir}); end
    checks++;
  endtask

  task automatic test_acquire_alternate();
    int seq[8]  = '{2, 0, 1, 0, 1, 0, 2, 2};
    bit hold[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      apply(seq[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL alternate[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL alternate[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if (k >= 1 && o0_locked !== 1'b0) begin errors++; $display("FAIL alternate_nolock[%0d] got=%b exp=0", k, o0_locked); end
      checks++;
      if (o0_hold !== hold[k]) begin errors++; $display("FAIL hold_pulse[%0d] got=%b exp=%b", k, o0_hold, hold[k]); end
      checks++;
    end
    apply(2);
    if (o0_hold !== 1'b1) begin errors++; $display("FAIL hold_repeat got=%b exp=1", o0_hold); end
    checks++;
  endtask

  task automatic test_err_saturation();
    int seq[6] = '{0, 2, 0, 2, 0, 2};
    int exp_e1[6] = '{0, 1, 2, 3, 3, 3};
    mid_reset();
    CLR = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply(seq[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL sat[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL sat[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if ({o1_serr, o1_err} !== {(k != 0), 2'(exp_e1[k])}) begin
        errors++; $display("FAIL sat_cnt[%0d] serr,err got=%b exp=%b", k, {o1_serr, o1_err}, {(k != 0), 2'(exp_e1[k])});
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    int seq[6] = '{0, 1, 2, 0, 1, 2};
    int post[3] = '{2, 3, 0};
    bit lk[3] = '{0, 0, 1};
    mid_reset();
    CLR = 1'b1;
    for (int k = 0; k < 6; k++) apply(seq[k]);
    if ({o0_locked, o0_err} !== {1'b1, 8'd1}) begin errors++; $display("FAIL pre_reset locked,err got=%h exp=%h", {o0_locked, o0_err}, {1'b1, 8'd1}); end
    checks++;
    mid_reset();
    if (obs0 !== 13'd0) begin errors++; $display("FAIL async_clear inst0 got=%h exp=0", obs0); end
    checks++;
    if (obs1 !== 13'd0) begin errors++; $display("FAIL async_clear inst1 got=%h exp=0", obs1); end
    checks++;
    CLR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(post[k]);
      if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL post_reset[%0d] inst0 got=%h exp=%h", k, obs0, exp_vec(0)); end
      checks++;
      if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL post_reset[%0d] inst1 got=%h exp=%h", k, obs1, exp_vec(1)); end
      checks++;
      if (o0_locked !== lk[k]) begin errors++; $display("FAIL post_reset_lock[%0d] got=%b exp=%b", k, o0_locked, lk[k]); end
      checks++;
    end
  endtask

  task automatic test_random();
    int bias;
    int r;
    int q;
    bias = 1;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        mid_reset();
        if (obs0 !== 13'd0) begin errors++; $display("FAIL rand_reset[%0d] inst0 got=%h exp=0", n, obs0); end
        checks++;
        CLR = 1'b1;
      end else begin
        if (r < 8) bias = 4 - bias;
        if (r < 60)      q = (m_prev + bias) % 4;
        else if (r < 75) q = (m_prev + 4 - bias) % 4;
        else if (r < 88) q = m_prev;
        else             q = (m_prev + 2) % 4;
        apply(q);
        if (obs0 !== exp_vec(0)) begin errors++; $display("FAIL rand[%0d] inst0 got=%h exp=%h", n, obs0, exp_vec(0)); end
        checks++;
        if (obs1 !== exp_vec(1)) begin errors++; $display("FAIL rand[%0d] inst1 got=%h exp=%h", n, obs1, exp_vec(1)); end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_dir_change();
    test_jump_relock();
    test_acquire_alternate();
    test_err_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
